if_fetch_stage: RTL and testbench

//   Instruction-fetch stage: owns the PC, issues word fetches to instruction memory over a req/ack

---
 rtl/if_fetch_stage_if.sv | 26 ++
 rtl/if_fetch_stage.sv | 92 +++++++++
 tb/tb_if_fetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: fetch-stage bus bundling branch/stall control, the imem req/ack port and the IF/ID register.
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PC_sel;
    logic [ADDR_W-1:0] branch_target;
    logic              stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] IF_ID_pc4;
    logic [DATA_W-1:0] IF_ID_instr;
    logic              IF_ID_valid;

    modport master (
        input  PC_sel, branch_target, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, IF_ID_pc4, IF_ID_instr, IF_ID_valid
    );

    modport slave (
        output PC_sel, branch_target, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, IF_ID_pc4, IF_ID_instr, IF_ID_valid
    );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, fetches words over req/ack and loads IF/ID, honouring branch redirect and stall.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    if_fetch_stage_if.master  bus
);
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drain_addr;
    logic [ADDR_W-1:0] r_buf_pc4;
    logic [DATA_W-1:0] r_buf_instr;
    logic [ADDR_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;

    assign w_pc_inc = r_pc + ADDR_W'(4);
    assign w_target = bus.branch_target & ~ADDR_W'(3);

    // A redirected request stays on the bus at its old address until memory acks it.
    assign bus.imem_req    = !reset && r_state != HOLD;
    assign bus.imem_addr   = r_state == DRAIN ? r_drain_addr : r_pc;
    assign bus.IF_ID_pc4   = r_pc4;
    assign bus.IF_ID_instr = r_instr;
    assign bus.IF_ID_valid = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
            r_buf_pc4    <= '0;
            r_buf_instr  <= '0;
            r_pc4        <= '0;
            r_instr      <= '0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.PC_sel) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        if (!bus.imem_ack) begin
                            r_state      <= DRAIN;
                            r_drain_addr <= r_pc;
                        end
                    end else if (bus.imem_ack) begin
                        r_pc <= w_pc_inc;
                        if (bus.stall) begin
                            r_buf_pc4   <= w_pc_inc;
                            r_buf_instr <= bus.imem_rdata;
                            r_state     <= HOLD;
                        end else begin
                            r_pc4   <= w_pc_inc;
                            r_instr <= bus.imem_rdata;
                            r_valid <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                    end
                end
                DRAIN: begin
                    if (bus.PC_sel) r_pc <= w_target;
                    if (bus.imem_ack) r_state <= FETCH;
                end
                HOLD: begin
                    if (bus.PC_sel) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        r_state <= FETCH;
                    end else if (!bus.stall) begin
                        r_pc4   <= r_buf_pc4;
                        r_instr <= r_buf_instr;
                        r_valid <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus random branch/stall/latency traffic against a cycle reference model.
module tb_if_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();
    if_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int cnt = 0;

    // Reference model: architectural PC, pending wrong-path request, stall buffer, IF/ID contents.
    logic [31:0] m_pc = RST_PC, m_drain = 0, m_buf_pc4 = 0, m_buf_instr = 0;
    logic [31:0] m_pc4 = 0, m_instr = 0;
    logic        m_v = 0, m_waste = 0, m_hold = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h8 ? 32'hDEAD : {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        req_s, a;
        logic [31:0] d, t, inc;
        @(negedge clk);
        req_s = bus.imem_req;
        bus.imem_ack = req_s && cnt >= lat;
        bus.imem_rdata = mem_word(bus.imem_addr);
        chk("req", {31'b0, req_s}, {31'b0, !reset && !m_hold});
        if (!reset) begin
            if (!m_hold) chk("addr", bus.imem_addr, m_waste ? m_drain : m_pc);
            chk("valid", {31'b0, bus.IF_ID_valid}, {31'b0, m_v});
            chk("instr", bus.IF_ID_instr, m_instr);
            if (m_v) chk("pc4", bus.IF_ID_pc4, m_pc4);
        end
        a = bus.imem_ack;
        d = bus.imem_rdata;
        t = bus.branch_target & ~32'h3;
        inc = m_pc + 32'd4;
        if (reset) begin
            m_pc = RST_PC; m_waste = 0; m_hold = 0; m_v = 0; m_instr = 0; m_pc4 = 0;
        end else if (m_hold) begin
            if (bus.PC_sel) begin
                m_pc = t; m_v = 0; m_instr = 0; m_hold = 0;
            end else if (!bus.stall) begin
                m_v = 1; m_pc4 = m_buf_pc4; m_instr = m_buf_instr; m_hold = 0;
            end
        end else if (m_waste) begin
            if (bus.PC_sel) m_pc = t;
            if (a) m_waste = 0;
        end else if (bus.PC_sel) begin
            if (!a) begin m_waste = 1; m_drain = m_pc; end
            m_pc = t; m_v = 0; m_instr = 0;
        end else if (a) begin
            if (bus.stall) begin m_buf_pc4 = inc; m_buf_instr = d; m_hold = 1; end
            else begin m_v = 1; m_pc4 = inc; m_instr = d; end
            m_pc = inc;
        end else if (!bus.stall) begin
            m_v = 0; m_instr = 0;
        end
        @(posedge clk);
        #1;
        cnt = reset ? 0 : (req_s && a) ? 0 : req_s ? cnt + 1 : cnt;
    endtask

    initial begin
        bus.PC_sel = 0; bus.branch_target = 0; bus.stall = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
        step(); step();
        reset = 0;
        // 1: back-to-back fetch from reset
        repeat (4) step();
        chk("t1_pc4", bus.IF_ID_pc4, 32'h10);
        chk("t1_addr", bus.imem_addr, 32'h10);
        // 2: branch with same-cycle ack
        bus.PC_sel = 1; bus.branch_target = 32'h40; step(); bus.PC_sel = 0;
        chk("t2_flush", {31'b0, bus.IF_ID_valid}, 32'h0);
        chk("t2_addr", bus.imem_addr, 32'h40);
        step();
        chk("t2_pc4", bus.IF_ID_pc4, 32'h44);
        // 3: branch during a slow request drains it first
        bus.PC_sel = 1; bus.branch_target = 32'h20; step(); bus.PC_sel = 0;
        lat = 3; step();
        bus.PC_sel = 1; bus.branch_target = 32'h80; step(); bus.PC_sel = 0;
        chk("t3_drain_addr", bus.imem_addr, 32'h20);
        step();
        chk("t3_drain_addr2", bus.imem_addr, 32'h20);
        step();
        chk("t3_new_addr", bus.imem_addr, 32'h80);
        chk("t3_valid", {31'b0, bus.IF_ID_valid}, 32'h0);
        lat = 0; step();
        chk("t3_pc4", bus.IF_ID_pc4, 32'h84);
        // 4: stall on ack buffers the word
        bus.PC_sel = 1; bus.branch_target = 32'h8; step(); bus.PC_sel = 0;
        bus.stall = 1; step(); step(); step();
        chk("t4_req", {31'b0, bus.imem_req}, 32'h0);
        bus.stall = 0; step();
        chk("t4_instr", bus.IF_ID_instr, 32'hDEAD);
        chk("t4_pc4", bus.IF_ID_pc4, 32'hC);
        chk("t4_addr", bus.imem_addr, 32'hC);
        // 5: branch in HOLD drops the buffer
        bus.stall = 1; step();
        bus.PC_sel = 1; bus.branch_target = 32'h100; step(); bus.PC_sel = 0; bus.stall = 0;
        chk("t5_valid", {31'b0, bus.IF_ID_valid}, 32'h0);
        chk("t5_addr", bus.imem_addr, 32'h100);
        // 6: PC wrap, then reset while draining
        bus.PC_sel = 1; bus.branch_target = 32'hFFFFFFFC; step(); bus.PC_sel = 0;
        step();
        chk("t6_pc4", bus.IF_ID_pc4, 32'h0);
        chk("t6_addr", bus.imem_addr, 32'h0);
        lat = 3; step();
        bus.PC_sel = 1; bus.branch_target = 32'h200; step(); bus.PC_sel = 0;
        reset = 1; step();
        chk("t6_rst_req", {31'b0, bus.imem_req}, 32'h0);
        reset = 0;
        chk("t6_addr_rst", bus.imem_addr, RST_PC);
        chk("t6_valid_rst", {31'b0, bus.IF_ID_valid}, 32'h0);
        lat = 0; step();
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(63) == 0;
            bus.PC_sel = $urandom_range(7) == 0;
            bus.branch_target = $urandom;
            bus.stall = $urandom_range(3) == 0;
            lat = $urandom_range(2);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
